// File: rtl/doorbell_rx.sv
// Completer-side NVMe doorbell receiver: decodes 1-DW BAR0 memory writes in the
// doorbell window into SQ-tail / CQ-head update pulses; every other TLP is dropped and counted.
module doorbell_rx #(
  parameter int                           C_DATA_WIDTH        = 128,
  parameter int                           KEEP_WIDTH          = C_DATA_WIDTH/32,
  parameter int                           AXI4_CQ_TUSER_WIDTH = 88,
  parameter int                           BAR_APERTURE_BITS   = 14,
  parameter logic [BAR_APERTURE_BITS-1:0] DB_BASE_OFFSET      = 14'h1000,
  parameter int                           NUM_QUEUES          = 16,
  parameter int                           QID_WIDTH           = 4
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic                           user_lnk_up,
  input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
  input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
  input  logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
  input  logic                           m_axis_cq_tlast,
  input  logic                           m_axis_cq_tvalid,
  output logic                           m_axis_cq_tready,
  output logic                           sqt_update,
  output logic                           cqh_update,
  output logic [QID_WIDTH-1:0]           db_qid,
  output logic [15:0]                    db_value,
  output logic [15:0]                    drop_count,
  output logic [1:0]                     rx_state
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_DATA  = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;
  localparam logic [31:0] LP_WIN   = 32'(NUM_QUEUES * 8);

  // Handshake: a beat transfers when m_axis_cq_tvalid && m_axis_cq_tready; tready is a
  // registered 1 whenever out of reset with the link up, so the CQ stream is never stalled.

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_nxt;
  logic                         r_tready;
  logic                         r_is_cq;
  logic [QID_WIDTH-1:0]         r_qid;
  logic                         r_sqt;
  logic                         r_cqh;
  logic [QID_WIDTH-1:0]         r_db_qid;
  logic [15:0]                  r_db_value;
  logic [15:0]                  r_drop_count;

  logic                         w_beat;
  logic [BAR_APERTURE_BITS-1:0] w_off;
  logic [BAR_APERTURE_BITS-1:0] w_rel;
  logic                         w_in_win;
  logic                         w_match;
  logic                         w_latch;
  logic                         w_drop;
  logic                         w_sqt_nxt;
  logic                         w_cqh_nxt;
  logic                         w_unused;

  assign w_beat   = m_axis_cq_tvalid && r_tready;
  assign w_off    = {m_axis_cq_tdata[BAR_APERTURE_BITS-1:2], 2'b00};
  assign w_rel    = w_off - DB_BASE_OFFSET;
  assign w_in_win = (w_off >= DB_BASE_OFFSET) && (32'(w_rel) < LP_WIN);
  assign w_match  = (m_axis_cq_tdata[78:75] == 4'b0001) &&
                    (m_axis_cq_tdata[74:64] == 11'd1) &&
                    (m_axis_cq_tdata[114:112] == 3'd0) &&
                    (m_axis_cq_tuser[3:0] == 4'b1111) &&
                    w_in_win;

  assign w_unused = ^{m_axis_cq_tkeep, m_axis_cq_tuser[AXI4_CQ_TUSER_WIDTH-1:4],
                      m_axis_cq_tdata[C_DATA_WIDTH-1:115], m_axis_cq_tdata[111:79],
                      m_axis_cq_tdata[63:BAR_APERTURE_BITS],
                      w_rel[BAR_APERTURE_BITS-1:QID_WIDTH+3], w_rel[1:0]};

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset)        r_state <= ST_IDLE;
    else if (!user_lnk_up) r_state <= ST_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_beat) w_state_nxt = m_axis_cq_tlast ? ST_IDLE :
                                          (w_match ? ST_DATA : ST_DRAIN);
      ST_DATA:  if (w_beat) w_state_nxt = m_axis_cq_tlast ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (w_beat && m_axis_cq_tlast) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // A matching descriptor that already carries tlast has no payload and is dropped.
  always_comb begin
    w_latch   = 1'b0;
    w_drop    = 1'b0;
    w_sqt_nxt = 1'b0;
    w_cqh_nxt = 1'b0;
    if (r_state == ST_IDLE && w_beat) begin
      w_latch = w_match && !m_axis_cq_tlast;
      w_drop  = !(w_match && !m_axis_cq_tlast);
    end
    if (r_state == ST_DATA && w_beat) begin
      w_sqt_nxt = !r_is_cq;
      w_cqh_nxt = r_is_cq;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_tready     <= 1'b0;
      r_sqt        <= 1'b0;
      r_cqh        <= 1'b0;
      r_db_qid     <= '0;
      r_db_value   <= '0;
      r_drop_count <= '0;
      r_qid        <= '0;
      r_is_cq      <= 1'b0;
    end else if (!user_lnk_up) begin
      r_tready     <= 1'b0;
      r_sqt        <= 1'b0;
      r_cqh        <= 1'b0;
      r_db_qid     <= '0;
      r_db_value   <= '0;
      r_drop_count <= '0;
      r_qid        <= '0;
      r_is_cq      <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      r_sqt    <= w_sqt_nxt;
      r_cqh    <= w_cqh_nxt;
      if (w_sqt_nxt || w_cqh_nxt) begin
        r_db_qid   <= r_qid;
        r_db_value <= m_axis_cq_tdata[15:0];
      end
      if (w_latch) begin
        r_qid   <= w_rel[QID_WIDTH+2:3];
        r_is_cq <= w_rel[2];
      end
      if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign m_axis_cq_tready = r_tready;
  assign sqt_update       = r_sqt;
  assign cqh_update       = r_cqh;
  assign db_qid           = r_db_qid;
  assign db_value         = r_db_value;
  assign drop_count       = r_drop_count;
  assign rx_state         = r_state;

endmodule
